sram_banked_wb_ctrl: RTL and testbench

SRAM_BANKED_WB_CTRL -- requirements
Module: sram_banked_wb_ctrl

---
 rtl/sram_banked_wb_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sram_banked_wb_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_banked_wb_ctrl.sv
// sram_banked_wb_ctrl
// Wishbone classic slave that maps a contiguous byte window onto NUM_BANKS
// dual-port SRAM macros (port 0 write-only, port 1 read-only, both clocked
// by wb_clk_i). Writes complete with ack one cycle after acceptance, reads
// two cycles after acceptance, out-of-window or misaligned requests end in
// a one-cycle err.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, async active-high reset
//   wbs_cyc_i/stb_i/we_i      Wishbone controls
//   wbs_sel_i, wbs_adr_i      byte selects, byte address
//   wbs_dat_i / wbs_dat_o     write data / registered read data
//   wbs_ack_o, wbs_err_o      registered terminations
//   sram_csb0_o .. din0_o     write port: per-bank select (low), mask, addr, data
//   sram_csb1_o, addr1_o      read port: per-bank select (low), addr
//   sram_dout1_i              read data, bank b at [32b+31:32b]
//
// state   | meaning
// IDLE    | waiting for cyc & stb; SRAM selects driven in the accept cycle
// RD_WAIT | SRAM read in flight; data captured at the end of this cycle
// ACK     | one-cycle ack pulse
// ERR     | one-cycle err pulse

module sram_banked_wb_ctrl #(
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic                      wbs_err_o,
  output logic [31:0]               wbs_dat_o,
  output logic [NUM_BANKS-1:0]      sram_csb0_o,
  output logic [3:0]                sram_wmask0_o,
  output logic [ADDR_WIDTH-1:0]     sram_addr0_o,
  output logic [31:0]               sram_din0_o,
  output logic [NUM_BANKS-1:0]      sram_csb1_o,
  output logic [ADDR_WIDTH-1:0]     sram_addr1_o,
  input  logic [32*NUM_BANKS-1:0]   sram_dout1_i
);

  localparam int unsigned BW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int unsigned BIW = (BW > 0) ? BW : 1;
  localparam logic [32:0] WIN_SIZE = 33'(NUM_BANKS) << (ADDR_WIDTH + 2);
  localparam logic [NUM_BANKS-1:0] BANK_ONE = 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_ACK     = 2'd2;
  localparam logic [1:0] S_ERR     = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [31:0]           dat_q, dat_d;
  logic [BIW-1:0]        bank_q, bank_d;
  logic [3:0]            sel_q, sel_d;

  logic [31:0]           off;
  logic [ADDR_WIDTH-1:0] word;
  logic [BIW-1:0]        bank;
  logic                  in_range;
  logic                  req, wr_go, rd_go, err_go;
  logic [NUM_BANKS-1:0]  bank_dec;
  logic [31:0]           rd_word, lane_mask;

  assign off  = wbs_adr_i - BASE_ADDR;
  assign word = off[ADDR_WIDTH+1:2];

  generate
    if (BW > 0) begin : g_bank
      assign bank = off[ADDR_WIDTH+BW+1:ADDR_WIDTH+2];
    end else begin : g_nobank
      assign bank = '0;
    end
  endgenerate

  assign in_range = (wbs_adr_i >= BASE_ADDR) && ({1'b0, off} < WIN_SIZE) &&
                    (wbs_adr_i[1:0] == 2'b00);

  // Reset gates acceptance so the SRAM selects go inactive the moment
  // reset asserts, even while the master still holds cyc/stb.
  assign req    = (state_q == S_IDLE) && wbs_cyc_i && wbs_stb_i && !wb_rst_i;
  assign wr_go  = req && in_range && wbs_we_i;
  assign rd_go  = req && in_range && !wbs_we_i;
  assign err_go = req && !in_range;

  assign bank_dec = BANK_ONE << bank;

  assign sram_csb0_o   = wr_go ? ~bank_dec : '1;
  assign sram_csb1_o   = rd_go ? ~bank_dec : '1;
  assign sram_addr0_o  = word;
  assign sram_addr1_o  = word;
  assign sram_din0_o   = wbs_dat_i;
  assign sram_wmask0_o = wbs_sel_i;

  assign rd_word   = sram_dout1_i[{bank_q, 5'd0} +: 32];
  assign lane_mask = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    bank_d  = bank_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (wr_go) begin
          state_d = S_ACK;
        end else if (rd_go) begin
          state_d = S_RD_WAIT;
          bank_d  = bank;
          sel_d   = wbs_sel_i;
        end else if (err_go) begin
          state_d = S_ERR;
          dat_d   = '0;
        end
      end
      S_RD_WAIT: begin
        // Master abandoned the cycle: drop the read silently.
        if (!wbs_cyc_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ACK;
          dat_d   = rd_word & lane_mask;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ack_d = (state_d == S_ACK);
  assign err_d = (state_d == S_ERR);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      bank_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      bank_q  <= bank_d;
      sel_q   <= sel_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_sram_banked_wb_ctrl.sv
// Bench for sram_banked_wb_ctrl: two behavioural SRAM banks, directed
// Wishbone transfers, and a response monitor fed by an expectation queue.

module tb_sram_banked_wb_ctrl;

  localparam int NB = 2;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]    sel = 4'h0;
  logic [31:0]   adr = 32'h0, dat_w = 32'h0;
  logic          ack, err;
  logic [31:0]   dat_r;
  logic [NB-1:0] csb0, csb1;
  logic [3:0]    wmask0;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   din0;
  logic [32*NB-1:0] dout1;

  always #5 clk = ~clk;

  sram_banked_wb_ctrl #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .BASE_ADDR(32'h3000_0000)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w),
    .wbs_ack_o(ack), .wbs_err_o(err), .wbs_dat_o(dat_r),
    .sram_csb0_o(csb0), .sram_wmask0_o(wmask0), .sram_addr0_o(addr0), .sram_din0_o(din0),
    .sram_csb1_o(csb1), .sram_addr1_o(addr1), .sram_dout1_i(dout1)
  );

  // Behavioural SRAM banks
  logic [31:0] mem [0:NB-1][0:(1<<AW)-1];
  logic [31:0] dout_r [0:NB-1];

  initial begin
    for (int b = 0; b < NB; b++) begin
      dout_r[b] = '0;
      for (int w = 0; w < (1 << AW); w++) mem[b][w] = '0;
    end
  end

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!csb0[b])
        for (int l = 0; l < 4; l++)
          if (wmask0[l]) mem[b][addr0][8*l +: 8] <= din0[8*l +: 8];
      if (!csb1[b]) dout_r[b] <= mem[b][addr1];
    end
  end

  assign dout1 = {dout_r[1], dout_r[0]};

  // Scoreboard
  typedef struct {
    logic        is_err;
    logic        is_rd;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] dat_hold = 32'h0;
  logic        prev_resp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_resp = 1'b0;
    end else begin
      if (ack || err) begin
        check("ack_err_exclusive", {31'b0, ack & err}, 32'h0);
        check("no_consecutive_resp", {31'b0, prev_resp}, 32'h0);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_resp: got ack=%0b err=%0b expected none at %0t", ack, err, $time);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("resp_is_err", {31'b0, err}, {31'b0, e.is_err});
          if (e.is_err) check("err_dat_zero", dat_r, 32'h0);
          else if (e.is_rd) check("rd_dat", dat_r, e.dat);
        end
      end
      prev_resp = ack | err;
    end
  end

  task automatic drive_req(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, input logic [1:0] e_csb0,
                           input logic [1:0] e_csb1, input logic [AW-1:0] e_word,
                           input logic chk_word);
    @(posedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    @(negedge clk);
    check("csb0", {30'b0, csb0}, {30'b0, e_csb0});
    check("csb1", {30'b0, csb1}, {30'b0, e_csb1});
    if (chk_word) begin
      if (w) begin
        check("addr0", {21'b0, addr0}, {21'b0, e_word});
        check("din0", din0, d);
        check("wmask0", {28'b0, wmask0}, {28'b0, s});
      end else begin
        check("addr1", {21'b0, addr1}, {21'b0, e_word});
      end
    end
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic [1:0] e_csb0, input logic [1:0] e_csb1,
                      input logic [AW-1:0] e_word, input logic e_err,
                      input logic [31:0] e_rd, input int e_lat);
    exp_t e;
    int   got;
    drive_req(w, a, s, d, e_csb0, e_csb1, e_word, !e_err);
    e.is_err = e_err;
    e.is_rd  = !w;
    e.dat    = e_rd;
    sb_q.push_back(e);
    got = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ack || err) begin
        got = k;
        break;
      end
    end
    if (got == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL resp_timeout: got no response expected one for adr 0x%08h", a);
    end else begin
      check("latency", got, e_lat);
    end
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0;
    if (e_err) dat_hold = 32'h0;
    else if (!w) dat_hold = e_rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_dat", dat_r, 32'h0);
    check("rst_csb", {30'b0, csb1, csb0}, 32'hF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // we, adr, sel, data, csb0, csb1, word, err, rd_exp, latency
    xfer(1, 32'h3000_0004, 4'hF, 32'hDEAD_BEEF, 2'b10, 2'b11, 11'd1, 0, 32'h0, 1);
    xfer(0, 32'h3000_0004, 4'hF, 32'h0,        2'b11, 2'b10, 11'd1, 0, 32'hDEAD_BEEF, 2);
    xfer(1, 32'h3000_0000, 4'hF, 32'h1234_5678, 2'b10, 2'b11, 11'd0, 0, 32'h0, 1);
    xfer(1, 32'h3000_2000, 4'hF, 32'hCAFE_F00D, 2'b01, 2'b11, 11'd0, 0, 32'h0, 1);
    xfer(0, 32'h3000_0000, 4'hF, 32'h0,        2'b11, 2'b10, 11'd0, 0, 32'h1234_5678, 2);
    xfer(0, 32'h3000_2000, 4'h3, 32'h0,        2'b11, 2'b01, 11'd0, 0, 32'h0000_F00D, 2);
    xfer(0, 32'h3000_4000, 4'hF, 32'h0,        2'b11, 2'b11, 11'd0, 1, 32'h0, 1);
    xfer(0, 32'h3000_0004, 4'hF, 32'h0,        2'b11, 2'b10, 11'd1, 0, 32'hDEAD_BEEF, 2);
    xfer(0, 32'h3000_0002, 4'hF, 32'h0,        2'b11, 2'b11, 11'd0, 1, 32'h0, 1);
    xfer(1, 32'h2FFF_FFFC, 4'hF, 32'h5555_AAAA, 2'b11, 2'b11, 11'd0, 1, 32'h0, 1);
    xfer(1, 32'h3000_2010, 4'hF, 32'h1122_3344, 2'b01, 2'b11, 11'd4, 0, 32'h0, 1);
    xfer(1, 32'h3000_2010, 4'h4, 32'h00AB_0000, 2'b01, 2'b11, 11'd4, 0, 32'h0, 1);
    xfer(0, 32'h3000_2010, 4'hF, 32'h0,        2'b11, 2'b01, 11'd4, 0, 32'h11AB_3344, 2);
    xfer(1, 32'h3000_3FFC, 4'hF, 32'hA5A5_0FF0, 2'b01, 2'b11, 11'h7FF, 0, 32'h0, 1);
    xfer(0, 32'h3000_3FFC, 4'hF, 32'h0,        2'b11, 2'b01, 11'h7FF, 0, 32'hA5A5_0FF0, 2);

    // Read abandoned in RD_WAIT, then a write accepted on the next cycle
    drive_req(0, 32'h3000_0008, 4'hF, 32'h0, 2'b11, 2'b10, 11'd2, 1);
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("abort_no_ack", {31'b0, ack | err}, 32'h0);
    xfer(1, 32'h3000_0008, 4'hF, 32'h0BAD_CAFE, 2'b10, 2'b11, 11'd2, 0, 32'h0, 1);
    check("abort_dat_held", dat_r, dat_hold);
    xfer(0, 32'h3000_0008, 4'hF, 32'h0, 2'b11, 2'b10, 11'd2, 0, 32'h0BAD_CAFE, 2);

    // Reset asserted during RD_WAIT while the master still drives cyc/stb
    drive_req(0, 32'h3000_0004, 4'hF, 32'h0, 2'b11, 2'b10, 11'd1, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_ack", {31'b0, ack}, 32'h0);
    check("midrst_err", {31'b0, err}, 32'h0);
    check("midrst_dat", dat_r, 32'h0);
    check("midrst_csb", {30'b0, csb1, csb0}, 32'hF);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 1'b0; stb = 1'b0;
    repeat (4) @(negedge clk);
    xfer(0, 32'h3000_0004, 4'hF, 32'h0, 2'b11, 2'b10, 11'd1, 0, 32'hDEAD_BEEF, 2);

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
